scale_rom_player: RTL

SCALE_ROM_PLAYER -- requirements
Module: scale_rom_player

---
 rtl/scale_rom_player.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/scale_rom_player.sv
// Plays a tone table from a combinational ROM: offer, hold, gap, then advance until the last entry.
// Optional build macro SCALE_SKIP_ZERO_EN: zero ROM entries are skipped instead of played as rests.
module scale_rom_player #(
    parameter int NOTE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    output logic [7:0]  rom_address,
    input  logic [23:0] rom_data,
    input  logic [7:0]  rom_last_address,
    output logic [23:0] tone,
    output logic        tone_valid,
    input  logic        tone_ready,
    output logic        playing,
    output logic        done
);

    localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        OFFER = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state;
    logic [7:0]       addr;
    logic [7:0]       last;
    logic [CNT_W-1:0] cnt;

    assign rom_address = addr;

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every
    // register sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            last       <= '0;
            cnt        <= '0;
            tone       <= '0;
            tone_valid <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else if (stop) begin
            // Abort silently: no done pulse, table position forgotten.
            state      <= IDLE;
            addr       <= '0;
            cnt        <= '0;
            tone       <= '0;
            tone_valid <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr    <= '0;
                        playing <= 1'b1;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    last <= rom_last_address;
`ifdef SCALE_SKIP_ZERO_EN
                    if (rom_data == '0) begin
                        if (addr == rom_last_address) begin
                            tone    <= '0;
                            playing <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            addr <= addr + 8'd1;
                        end
                    end else begin
                        tone       <= rom_data;
                        tone_valid <= 1'b1;
                        state      <= OFFER;
                    end
`else
                    tone       <= rom_data;
                    tone_valid <= 1'b1;
                    state      <= OFFER;
`endif
                end

                OFFER: begin
                    if (tone_ready) begin
                        tone_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    if (!pause) begin
                        if (cnt == NOTE_LAST) begin
                            cnt <= '0;
                            if (GAP_CYCLES > 0) begin
                                tone  <= '0;
                                state <= GAP;
                            end else if (addr == last) begin
                                tone    <= '0;
                                playing <= 1'b0;
                                done    <= 1'b1;
                                state   <= DONE;
                            end else begin
                                addr  <= addr + 8'd1;
                                state <= LOAD;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                GAP: begin
                    if (!pause) begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (addr == last) begin
                                playing <= 1'b0;
                                done    <= 1'b1;
                                state   <= DONE;
                            end else begin
                                addr  <= addr + 8'd1;
                                state <= LOAD;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    tone       <= '0;
                    tone_valid <= 1'b0;
                    playing    <= 1'b0;
                end
            endcase
        end
    end

endmodule
